// File: rtl/muldiv_if.sv
// muldiv_if: pipeline-side handshake and HI/LO bus of the multiply/divide sequencer
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, src_a, src_b, hi_we, lo_we, wdata,
                    input  busy, done, div_by_zero, hi, lo);
    modport slave  (input  start, op, src_a, src_b, hi_we, lo_we, wdata,
                    output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers
module muldiv_ctrl #(parameter int WIDTH = 32) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_r;
    logic               neg_q, neg_r, dz, done_r, dz_r;
    logic [WIDTH-1:0]   a_raw, m, hi_r, lo_r, a_abs, b_abs;
    logic [2*WIDTH-1:0] acc, acc_nx, prod;
    logic [WIDTH:0]     sum, cand, diff;
    logic               a_neg, b_neg, accept;
    assign accept = state == IDLE && bus.start;
    assign a_neg  = ~bus.op[0] & bus.src_a[WIDTH-1];
    assign b_neg  = ~bus.op[0] & bus.src_b[WIDTH-1];
    assign a_abs  = a_neg ? -bus.src_a : bus.src_a;
    assign b_abs  = b_neg ? -bus.src_b : bus.src_b;
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};
    assign cand   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff   = cand - {1'b0, m};
    assign acc_nx = !op_r[1] ? {sum, acc[WIDTH-1:1]}
                  : diff[WIDTH] ? {cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                  : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign prod   = neg_q ? -acc : acc;
    assign bus.busy        = state != IDLE;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;
    always_comb begin
        state_nx = state;
        if (accept) state_nx = ITER;
        else if (state == ITER && cnt == CW'(WIDTH-1)) state_nx = FIX;
        else if (state == FIX) state_nx = IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt    <= '0;
            op_r   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            a_raw  <= '0;
            m      <= '0;
            acc    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= state == FIX;
            dz_r   <= state == FIX && dz;
            if (accept) begin
                cnt   <= '0;
                op_r  <= bus.op;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                dz    <= bus.op[1] && bus.src_b == '0;
                a_raw <= bus.src_a;
                m     <= bus.op[1] ? b_abs : a_abs;
                acc   <= {{WIDTH{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
            end else if (state == IDLE) begin
                if (bus.hi_we) hi_r <= bus.wdata;
                if (bus.lo_we) lo_r <= bus.wdata;
            end else if (state == ITER) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
            end else if (state == FIX) begin
                hi_r <= dz ? a_raw
                      : op_r[1] ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                      : prod[2*WIDTH-1:WIDTH];
                lo_r <= dz ? '1
                      : op_r[1] ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0])
                      : prod[WIDTH-1:0];
            end
        end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the MIPS datapath. Executes MULT, MULTU, DIV and DIVU over a fixed number of cycles.
- Owns the architectural HI/LO registers and drives a busy/done handshake so the pipeline controller can stall on MFHI/MFLO.
- Sits beside the main ALU. Operands come from the register file read ports (rs→src_a, rt→src_b).

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  valid with done; divisor was 0 on a DIV/DIVU
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, active-high):
  - State=IDLE; hi=lo=0; busy=done=div_by_zero=0.
  - Any in-flight operation is abandoned. Reset mid-operation leaves no partial result in HI/LO.
- States: IDLE → ITER → FIX → IDLE.
- IDLE:
  - On an edge with start=1, latch op, |src_a|, |src_b| and the operand signs (signed ops only), clear the iteration counter, go to ITER.
  - busy rises after that edge.
- ITER, exactly WIDTH edges:
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per edge.
  - The counter reaching WIDTH-1 moves the state to FIX.
- FIX, one edge:
  - Apply sign correction and write hi/lo.
  - Assert done (and div_by_zero if applicable) for exactly the following cycle; busy falls on the same edge. Go to IDLE.
- Latency: start accepted at edge E0; hi/lo updated at edge E(WIDTH+1) = E33; done high for the cycle after E33. busy is high for 33 cycles.
- A new start is accepted in the done cycle; back-to-back operations have no bubble.
- Multiply results:
  - hi = upper WIDTH bits of the product, lo = lower WIDTH bits.
  - Signed result is negated when the operand signs differ.
- Divide results:
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - DIVU treats both operands as unsigned.
- Division by zero: same latency; hi=src_a as latched, lo=all ones; div_by_zero=1 with done.
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0, div_by_zero=0.
- start while busy: ignored, not queued.
- hi_we/lo_we:
  - In IDLE, write wdata on the next edge. Both may be asserted together.
  - While busy: dropped.
  - Same edge as an accepted start: start wins and the write is dropped.
- hi/lo hold their value at all other times, including during ITER. Intermediate values live in internal registers only.
- op/src_a/src_b are don't-care after the accept edge.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF×0xFFFFFFFF → done at cycle 34 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- MULT 0xFFFFFFFD(-3)×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then, in the done cycle, start DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF (no bubble).
- DIVU 100/0 → div_by_zero=1 with done; hi=100, lo=0xFFFFFFFF. DIV 0x80000000/-1 → lo=0x80000000, hi=0, div_by_zero=0.
- Start DIVU 1000/7; pulse start with other operands and hi_we=1 (wdata=0x1234) mid-operation → both ignored; final lo=142, hi=6.
- IDLE: hi_we=1, lo_we=1, wdata=0xA5A5A5A5 → both registers =0xA5A5A5A5 next edge. Same-edge start+lo_we → lo holds the operation result, not wdata.
- Assert reset at cycle 10 of a MULT → hi=lo=0, busy=0 immediately; no done pulse. A start after reset release runs normally.
